// File: rtl/proj_pkg.sv
// proj_pkg: shared defaults, hash constants and FSM encoding for the minhash sketcher
package proj_pkg;
  localparam int DEF_BASE_LEN = 2;
  localparam int DEF_SIG_LEN = 32;
  localparam int MAX_LANES = 8;
  localparam logic [63:0] HASH_PRIME = 64'h9E37_79B9_7F4A_7C15;
  localparam logic [63:0] SEEDS [MAX_LANES] = '{
    64'h243F_6A88_85A3_08D3, 64'h1319_8A2E_0370_7344,
    64'hA409_3822_299F_31D0, 64'h082E_FA98_EC4E_6C89,
    64'h4528_21E6_38D0_1377, 64'hBE54_66CF_34E9_0C6C,
    64'hC0AC_29B7_C97C_50DD, 64'h3F84_D5B5_B547_0917
  };
  typedef enum logic [1:0] {SCAN, DRAIN, OUT} fsm_e;
endpackage

// File: rtl/proj_hash_lane.sv
// proj_hash_lane: combinational seeded k-mer hash, oldest base (MSB slot) folded in first
module proj_hash_lane import proj_pkg::*; #(
  parameter int BASE_LEN = DEF_BASE_LEN,
  parameter int KMER_LEN = 12,
  parameter int SIG_LEN = DEF_SIG_LEN,
  parameter logic [SIG_LEN-1:0] SEED = '0
) (
  input  logic [KMER_LEN*BASE_LEN-1:0] kmer_i,
  output logic [SIG_LEN-1:0]           sig_o
);
  localparam logic [SIG_LEN-1:0] P = SIG_LEN'(HASH_PRIME);
  logic [SIG_LEN-1:0] h;
  always_comb begin
    h = SEED;
    for (int i = KMER_LEN - 1; i >= 0; i--) h = (h ^ SIG_LEN'(kmer_i[i*BASE_LEN +: BASE_LEN])) * P;
    sig_o = h ^ (h >> 15);
  end
endmodule

// File: rtl/proj_multi_minhash.sv
// proj_multi_minhash: streaming multi-lane minhash sketch of a nucleotide sequence
module proj_multi_minhash import proj_pkg::*; #(
  parameter int BASE_LEN = DEF_BASE_LEN,
  parameter int KMER_LEN = 12,
  parameter int NUM_HASH = 4,
  parameter int SEQ_MAX_LEN = 1024,
  parameter int SIG_LEN = DEF_SIG_LEN,
  localparam int INDICE_LEN = $clog2(SEQ_MAX_LEN)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  input  logic [BASE_LEN-1:0]              in_data,
  input  logic                             in_last,
  output logic                             in_ready,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_HASH*SIG_LEN-1:0]      out_sig,
  output logic [NUM_HASH*INDICE_LEN-1:0]   out_idx,
  output logic [INDICE_LEN:0]              out_count,
  output logic                             out_empty,
  output logic                             out_ovf
);
  localparam int CW = INDICE_LEN + 1;
  localparam int WW = KMER_LEN * BASE_LEN;
  localparam logic [CW-1:0] KL = CW'(KMER_LEN);
  localparam logic [CW-1:0] MX = CW'(SEQ_MAX_LEN);
  fsm_e st_q, st_d;
  logic [WW-1:0] win_q, win_d, win_sh;
  logic [CW-1:0] cnt_q, cnt_d, ocnt_q, ocnt_d, cnt_inc;
  logic ovf_q, ovf_d, pv_q, pv_d, acc, full, done;
  logic [INDICE_LEN-1:0] pidx_q, pidx_d;
  logic [SIG_LEN-1:0] hs [NUM_HASH];
  logic [SIG_LEN-1:0] ph_q [NUM_HASH];
  logic [SIG_LEN-1:0] ph_d [NUM_HASH];
  logic [SIG_LEN-1:0] min_q [NUM_HASH];
  logic [SIG_LEN-1:0] min_d [NUM_HASH];
  logic [INDICE_LEN-1:0] midx_q [NUM_HASH];
  logic [INDICE_LEN-1:0] midx_d [NUM_HASH];
  assign in_ready = st_q == SCAN && !rst_n;
  assign out_valid = st_q == OUT;
  assign acc = in_valid && in_ready;
  assign full = cnt_q == MX;
  assign cnt_inc = full ? cnt_q : cnt_q + 1'b1;
  assign done = out_valid && out_ready;
  assign win_sh = {win_q[WW-BASE_LEN-1:0], in_data};
  assign out_count = ocnt_q;
  assign out_ovf = ovf_q;
  assign out_empty = out_valid && cnt_q < KL;
  // lanes hash the window as it will look after this base is shifted in
  for (genvar l = 0; l < NUM_HASH; l++) begin : g_lane
    proj_hash_lane #(
      .BASE_LEN(BASE_LEN), .KMER_LEN(KMER_LEN), .SIG_LEN(SIG_LEN), .SEED(SIG_LEN'(SEEDS[l]))
    ) u_hash (.kmer_i(win_sh), .sig_o(hs[l]));
    assign out_sig[l*SIG_LEN +: SIG_LEN] = min_q[l];
    assign out_idx[l*INDICE_LEN +: INDICE_LEN] = midx_q[l];
  end
  always_comb begin
    win_d = win_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    ocnt_d = ocnt_q;
    min_d = min_q;
    midx_d = midx_q;
    ph_d = hs;
    pv_d = acc && !full && cnt_inc >= KL;
    pidx_d = INDICE_LEN'(cnt_inc - KL);
    st_d = st_q == SCAN ? (acc && in_last ? DRAIN : SCAN) : st_q == DRAIN ? OUT : (out_ready ? SCAN : OUT);
    if (acc) begin
      win_d = win_sh;
      cnt_d = cnt_inc;
      ovf_d = ovf_q || full;
    end
    // strict compare keeps the earliest index on ties
    if (pv_q) begin
      ocnt_d = ocnt_q + 1'b1;
      for (int l = 0; l < NUM_HASH; l++)
        if (ph_q[l] < min_q[l]) begin
          min_d[l] = ph_q[l];
          midx_d[l] = pidx_q;
        end
    end
    if (done) begin
      win_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
      ocnt_d = '0;
      min_d = '{default: '1};
      midx_d = '{default: '0};
    end
  end
  always_ff @(posedge clk) begin
    if (rst_n) begin
      st_q <= SCAN;
      win_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      pv_q <= 1'b0;
      pidx_q <= '0;
      ph_q <= '{default: '0};
      ocnt_q <= '0;
      min_q <= '{default: '1};
      midx_q <= '{default: '0};
    end else begin
      st_q <= st_d;
      win_q <= win_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      pv_q <= pv_d;
      pidx_q <= pidx_d;
      ph_q <= ph_d;
      ocnt_q <= ocnt_d;
      min_q <= min_d;
      midx_q <= midx_d;
    end
  end
endmodule

// File: tb/tb_proj_multi_minhash.sv
// tb_proj_multi_minhash: directed scoreboard bench with an independent golden minhash model
module tb_proj_multi_minhash;
  import proj_pkg::*;
  localparam int K = 3, NH = 2, SMAX = 8, SL = 32, BL = 2, IL = 3;
  logic clk = 1'b0, rst_n = 1'b1, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [BL-1:0] in_data = '0;
  logic in_ready, out_valid, out_empty, out_ovf;
  logic [NH*SL-1:0] out_sig;
  logic [NH*IL-1:0] out_idx;
  logic [IL:0] out_count;
  typedef struct {
    logic [NH*SL-1:0] sig;
    logic [NH*IL-1:0] idx;
    logic [IL:0] cnt;
    logic empty;
    logic ovf;
  } exp_t;
  exp_t sb[$];
  int tests = 0, fails = 0, seq_n = 0;
  logic [BL-1:0] seq [32];

  proj_multi_minhash #(.BASE_LEN(BL), .KMER_LEN(K), .NUM_HASH(NH), .SEQ_MAX_LEN(SMAX), .SIG_LEN(SL)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .out_sig(out_sig),
    .out_idx(out_idx), .out_count(out_count), .out_empty(out_empty), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] mh(int lane, int st);
    logic [31:0] h = SEEDS[lane][31:0];
    for (int j = 0; j < K; j++) h = (h ^ 32'(seq[st+j])) * HASH_PRIME[31:0];
    return h ^ (h >> 15);
  endfunction

  function automatic exp_t make_exp();
    exp_t e;
    int nb = seq_n > SMAX ? SMAX : seq_n;
    int nk = nb >= K ? nb - K + 1 : 0;
    logic [31:0] h;
    e.sig = '1;
    e.idx = '0;
    e.cnt = (IL+1)'(nk);
    e.empty = seq_n < K;
    e.ovf = seq_n > SMAX;
    for (int i = 0; i < nk; i++)
      for (int l = 0; l < NH; l++) begin
        h = mh(l, i);
        if (h < e.sig[l*SL +: SL]) begin
          e.sig[l*SL +: SL] = h;
          e.idx[l*IL +: IL] = IL'(i);
        end
      end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_out(input string tag, input exp_t e);
    check({tag, "_sig"}, out_sig, e.sig);
    check({tag, "_idx"}, 64'(out_idx), 64'(e.idx));
    check({tag, "_count"}, 64'(out_count), 64'(e.cnt));
    check({tag, "_empty"}, 64'(out_empty), 64'(e.empty));
    check({tag, "_ovf"}, 64'(out_ovf), 64'(e.ovf));
  endtask

  task automatic send();
    int t;
    sb.push_back(make_exp());
    for (int i = 0; i < seq_n; i++) begin
      in_valid = 1'b1;
      in_data = seq[i];
      in_last = i == seq_n - 1;
      t = 0;
      while (!in_ready && t < 50) begin step(); t++; end
      check("in_ready", 64'(in_ready), 64'd1);
      step();
    end
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic recv(input int hold);
    exp_t e;
    int t = 0;
    while (!out_valid && t < 50) begin step(); t++; end
    check("out_valid", 64'(out_valid), 64'd1);
    check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check_out("res", e);
      for (int c = 0; c < hold; c++) begin
        step();
        check_out("hold", e);
        check("hold_in_ready", 64'(in_ready), 64'd0);
        check("hold_valid", 64'(out_valid), 64'd1);
      end
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("post_valid", 64'(out_valid), 64'd0);
    check("post_in_ready", 64'(in_ready), 64'd1);
    check("fresh_sig", out_sig, {64{1'b1}});
    check("fresh_count", 64'(out_count), 64'd0);
  endtask

  task automatic load_acgta();
    seq[0] = 2'd0; seq[1] = 2'd1; seq[2] = 2'd2; seq[3] = 2'd3; seq[4] = 2'd0;
    seq_n = 5;
  endtask

  initial begin
    step();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sig", out_sig, {64{1'b1}});
    check("rst_idx", 64'(out_idx), 64'd0);
    check("rst_count", 64'(out_count), 64'd0);
    check("rst_empty", 64'(out_empty), 64'd0);
    check("rst_ovf", 64'(out_ovf), 64'd0);
    rst_n = 1'b0;
    step();
    check("rel_in_ready", 64'(in_ready), 64'd1);
    // two bases: shorter than a k-mer
    seq[0] = 2'd1; seq[1] = 2'd2; seq_n = 2;
    send();
    recv(0);
    // single base with in_last
    seq[0] = 2'd3; seq_n = 1;
    send();
    recv(0);
    // ACGTA with latency check and a long back-pressure hold
    load_acgta();
    send();
    check("lat_drain", 64'(out_valid), 64'd0);
    step();
    check("lat_out", 64'(out_valid), 64'd1);
    recv(10);
    // identical bases: ties keep index 0
    for (int i = 0; i < 7; i++) seq[i] = 2'd0;
    seq_n = 7;
    send();
    recv(0);
    // overflow beyond SEQ_MAX_LEN
    for (int i = 0; i < 12; i++) seq[i] = BL'($urandom_range(0, 3));
    seq_n = 12;
    send();
    recv(0);
    // mid-sequence reset discards the partial sketch
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data = BL'(i + 1);
      in_last = 1'b0;
      step();
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("after_rst_no_valid", 64'(out_valid), 64'd0);
    end
    load_acgta();
    send();
    recv(0);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
